// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory read/write port. Writes are buffered
// one deep per master and always win over reads; round-robin within each class.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_rd_en,
    input  logic [AW-1:0] m0_rd_addr,
    output logic [DW-1:0] m0_rd_data,
    output logic          m0_rd_valid,
    input  logic          m0_wr_en,
    input  logic [AW-1:0] m0_wr_addr,
    input  logic [DW-1:0] m0_wr_data,
    input  logic          m1_rd_en,
    input  logic [AW-1:0] m1_rd_addr,
    output logic [DW-1:0] m1_rd_data,
    output logic          m1_rd_valid,
    input  logic          m1_wr_en,
    input  logic [AW-1:0] m1_wr_addr,
    input  logic [DW-1:0] m1_wr_data,
    output logic          s_rd_en,
    output logic [AW-1:0] s_rd_addr,
    input  logic [DW-1:0] s_rd_data,
    input  logic          s_rd_valid,
    output logic          s_wr_en,
    output logic [AW-1:0] s_wr_addr,
    output logic [DW-1:0] s_wr_data,
    output logic          busy,
    output logic [1:0]    wr_ovf
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_rr;
    logic          r_gnt;
    logic [1:0]    r_wb_vld;
    logic [AW-1:0] r_wb_addr [2];
    logic [DW-1:0] r_wb_data [2];
    logic [1:0]    r_wr_ovf;
    logic          r_s_rd_en;
    logic [AW-1:0] r_s_rd_addr;
    logic          r_s_wr_en;
    logic [AW-1:0] r_s_wr_addr;
    logic [DW-1:0] r_s_wr_data;

    logic [1:0]    w_wr_en_in;
    logic [AW-1:0] w_wr_addr_in [2];
    logic [DW-1:0] w_wr_data_in [2];
    logic [AW-1:0] w_rd_addr_in [2];
    logic [1:0]    w_wr_pend;
    logic [1:0]    w_rd_req;
    logic          w_grant_wr;
    logic          w_grant_rd;
    logic          w_sel;
    logic [1:0]    w_drain;

    assign w_wr_en_in      = {m1_wr_en, m0_wr_en};
    assign w_wr_addr_in[0] = m0_wr_addr;
    assign w_wr_addr_in[1] = m1_wr_addr;
    assign w_wr_data_in[0] = m0_wr_data;
    assign w_wr_data_in[1] = m1_wr_data;
    assign w_rd_addr_in[0] = m0_rd_addr;
    assign w_rd_addr_in[1] = m1_rd_addr;
    assign w_rd_req        = {m1_rd_en, m0_rd_en};
    // An incoming write pulse counts as pending so it is served ahead of a same-cycle read.
    assign w_wr_pend       = r_wb_vld | w_wr_en_in;
    assign w_drain         = {w_grant_wr & w_sel, w_grant_wr & ~w_sel};

    function automatic logic pick(input logic [1:0] req, input logic rr);
        return (req == 2'b11) ? rr : req[1];
    endfunction

    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        w_sel      = r_rr;
        case (r_state)
            IDLE: begin
                if (|w_wr_pend) begin
                    w_grant_wr = 1'b1;
                    w_sel      = pick(w_wr_pend, r_rr);
                    w_next     = WRITE;
                end else if (|w_rd_req) begin
                    w_grant_rd = 1'b1;
                    w_sel      = pick(w_rd_req, r_rr);
                    w_next     = READ;
                end
            end
            READ:    if (s_rd_valid) w_next = IDLE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= 1'b0;
            r_gnt       <= 1'b0;
            r_wb_vld    <= 2'b00;
            r_wr_ovf    <= 2'b00;
            r_s_rd_en   <= 1'b0;
            r_s_rd_addr <= '0;
            r_s_wr_en   <= 1'b0;
            r_s_wr_addr <= '0;
            r_s_wr_data <= '0;
            for (int i = 0; i < 2; i++) begin
                r_wb_addr[i] <= '0;
                r_wb_data[i] <= '0;
            end
        end else begin
            r_s_wr_en <= w_grant_wr;
            if (w_grant_wr) begin
                r_s_wr_addr <= r_wb_vld[w_sel] ? r_wb_addr[w_sel] : w_wr_addr_in[w_sel];
                r_s_wr_data <= r_wb_vld[w_sel] ? r_wb_data[w_sel] : w_wr_data_in[w_sel];
            end
            if (w_grant_rd) begin
                r_s_rd_en   <= 1'b1;
                r_s_rd_addr <= w_rd_addr_in[w_sel];
                r_gnt       <= w_sel;
            end else if (r_state == READ && s_rd_valid) begin
                r_s_rd_en <= 1'b0;
            end
            if (w_grant_wr || w_grant_rd) r_rr <= ~w_sel;
            // A pulse granted straight from the inputs with an empty buffer never lands in it.
            for (int i = 0; i < 2; i++) begin
                if (w_drain[i]) r_wb_vld[i] <= 1'b0;
                if (w_wr_en_in[i]) begin
                    if (r_wb_vld[i] && !w_drain[i]) begin
                        r_wr_ovf[i] <= 1'b1;
                    end else if (r_wb_vld[i] || !w_drain[i]) begin
                        r_wb_vld[i]  <= 1'b1;
                        r_wb_addr[i] <= w_wr_addr_in[i];
                        r_wb_data[i] <= w_wr_data_in[i];
                    end
                end
            end
        end
    end

    assign m0_rd_data  = s_rd_data;
    assign m1_rd_data  = s_rd_data;
    assign m0_rd_valid = (r_state == READ) && s_rd_valid && !r_gnt;
    assign m1_rd_valid = (r_state == READ) && s_rd_valid && r_gnt;
    assign s_rd_en     = r_s_rd_en;
    assign s_rd_addr   = r_s_rd_addr;
    assign s_wr_en     = r_s_wr_en;
    assign s_wr_addr   = r_s_wr_addr;
    assign s_wr_data   = r_s_wr_data;
    assign busy        = (r_state != IDLE);
    assign wr_ovf      = r_wr_ovf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed master traffic against a
// latency-programmable memory model; a negedge monitor checks every slave/master event.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_rd_en, m1_rd_en, m0_wr_en, m1_wr_en;
    logic [AW-1:0] m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic          m0_rd_valid, m1_rd_valid;
    logic          s_rd_en, s_rd_valid, s_wr_en, busy;
    logic [AW-1:0] s_rd_addr, s_wr_addr;
    logic [DW-1:0] s_rd_data, s_wr_data;
    logic [1:0]    wr_ovf;

    int            lat;
    logic          force_valid;
    int            cnt = 0;
    logic [DW-1:0] mem [0:255];

    typedef struct packed {
        logic          kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sev_t;

    sev_t          exp_s[$];
    int            exp_len[$];
    logic [DW-1:0] exp_rd0[$];
    logic [DW-1:0] exp_rd1[$];
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rd_en(m0_rd_en), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
        .m0_wr_en(m0_wr_en), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
        .m1_rd_en(m1_rd_en), .m1_rd_addr(m1_rd_addr), .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
        .m1_wr_en(m1_wr_en), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
        .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
        .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .busy(busy), .wr_ovf(wr_ovf)
    );

    // Memory model: s_rd_valid arrives in the lat-th cycle of an s_rd_en episode.
    assign s_rd_data  = mem[s_rd_addr[9:2]];
    assign s_rd_valid = (s_rd_en && cnt == lat - 1) || force_valid;
    always @(posedge clk) cnt <= s_rd_en ? cnt + 1 : 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[8'h08] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (s_wr_en) mem[s_wr_addr[9:2]] = s_wr_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: actual event %h, required none", name, act);
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_s.push_back({1'b0, a, d});
    endtask

    task automatic exp_rd(input logic [AW-1:0] a, input int len);
        exp_s.push_back({1'b1, a, 32'h0});
        exp_len.push_back(len);
    endtask

    initial begin
        logic prev_rd;
        int   run_len;
        sev_t e;
        prev_rd = 1'b0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (s_wr_en) begin
                if (exp_s.size() == 0) unexpected("s_wr", {s_wr_addr, s_wr_data});
                else begin
                    e = exp_s.pop_front();
                    check("s_event_wr", {1'b0, s_wr_addr, s_wr_data}, e);
                end
            end
            if (s_rd_en && !prev_rd) begin
                if (exp_s.size() == 0) unexpected("s_rd", s_rd_addr);
                else begin
                    e = exp_s.pop_front();
                    check("s_event_rd", {1'b1, s_rd_addr, 32'h0}, e);
                end
            end
            if (s_rd_en) run_len++;
            else if (run_len > 0) begin
                if (exp_len.size() == 0) unexpected("rd_len", run_len);
                else begin
                    int l;
                    l = exp_len.pop_front();
                    if (l != 0) check("s_rd_en_len", run_len, l);
                end
                run_len = 0;
            end
            if (m0_rd_valid) begin
                if (exp_rd0.size() == 0) unexpected("m0_rd_valid", m0_rd_data);
                else check("m0_rd_data", m0_rd_data, exp_rd0.pop_front());
            end
            if (m1_rd_valid) begin
                if (exp_rd1.size() == 0) unexpected("m1_rd_valid", m1_rd_data);
                else check("m1_rd_data", m1_rd_data, exp_rd1.pop_front());
            end
            prev_rd = s_rd_en;
        end
    end

    // One clock: masters drop rd_en at the edge ending their valid cycle; write pulses last one cycle.
    task automatic step();
        logic v0, v1;
        @(negedge clk);
        v0 = m0_rd_valid;
        v1 = m1_rd_valid;
        @(posedge clk);
        #1;
        if (v0) m0_rd_en = 1'b0;
        if (v1) m1_rd_en = 1'b0;
        m0_wr_en = 1'b0;
        m1_wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int idle, k;
        idle = 0;
        k = 0;
        while (idle < 3 && k < 200) begin
            step();
            k++;
            if (!m0_rd_en && !m1_rd_en && !busy) idle++;
            else idle = 0;
        end
        if (idle < 3) begin
            n_checks++;
            $display("FAIL %s_timeout: actual busy=%b after %0d cycles, required idle", name, busy, k);
        end
        check(name, exp_s.size() + exp_rd0.size() + exp_rd1.size() + exp_len.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m0_rd_en = 1'b0;
        m1_rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {m0_rd_en, m1_rd_en, m0_wr_en, m1_wr_en} = 4'b0;
        {m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr} = '0;
        {m0_wr_data, m1_wr_data} = '0;
        lat = 3;
        force_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, s_rd_en, s_wr_en, wr_ovf}, 0);
        check("rst_addr_data", {s_rd_addr, s_wr_addr, s_wr_data}, 0);
        check("rst_rd_valid", {m0_rd_valid, m1_rd_valid}, 0);
        rst_n = 1'b1;

        // Single m0 read, slave latency 3.
        exp_rd(16'h0020, 3);
        exp_rd0.push_back(32'hDEAD_BEEF);
        m0_rd_addr = 16'h0020;
        m0_rd_en = 1'b1;
        drain("t1_single_read");

        // Simultaneous reads after reset, then m0 alone, then both again.
        do_reset();
        lat = 2;
        exp_rd(16'h0010, 2);
        exp_rd(16'h0014, 2);
        exp_rd0.push_back(32'hC0DE_0004);
        exp_rd1.push_back(32'hC0DE_0005);
        m0_rd_addr = 16'h0010;
        m1_rd_addr = 16'h0014;
        m0_rd_en = 1'b1;
        m1_rd_en = 1'b1;
        drain("t2_both_rd_first");
        exp_rd(16'h0018, 2);
        exp_rd0.push_back(32'hC0DE_0006);
        m0_rd_addr = 16'h0018;
        m0_rd_en = 1'b1;
        drain("t2_m0_alone");
        exp_rd(16'h0014, 2);
        exp_rd(16'h0010, 2);
        exp_rd1.push_back(32'hC0DE_0005);
        exp_rd0.push_back(32'hC0DE_0004);
        m0_rd_addr = 16'h0010;
        m1_rd_addr = 16'h0014;
        m0_rd_en = 1'b1;
        m1_rd_en = 1'b1;
        drain("t2_both_rd_repeat");

        // Write beats a same-cycle read.
        lat = 3;
        exp_wr(16'h0040, 32'h1234_5678);
        exp_rd(16'h0030, 3);
        exp_rd1.push_back(32'hC0DE_000C);
        m0_wr_addr = 16'h0040;
        m0_wr_data = 32'h1234_5678;
        m0_wr_en = 1'b1;
        m1_rd_addr = 16'h0030;
        m1_rd_en = 1'b1;
        drain("t3_write_first");

        // Write-buffer overflow during a long read.
        lat = 10;
        exp_rd(16'h0060, 10);
        exp_rd1.push_back(32'hC0DE_0018);
        exp_wr(16'h0070, 32'hAAAA_0000);
        m1_rd_addr = 16'h0060;
        m1_rd_en = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            m0_wr_addr = 16'h0070 + 16'(4 * k);
            m0_wr_data = 32'hAAAA_0000 + 32'(k);
            m0_wr_en = 1'b1;
            step();
        end
        check("ovf_after_pulses", wr_ovf, 2'b01);
        drain("t4_overflow");
        check("ovf_sticky", wr_ovf, 2'b01);

        // Reset during a read, then a late slave strobe.
        exp_rd(16'h0020, 0);
        m0_rd_addr = 16'h0020;
        m0_rd_en = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        m0_rd_en = 1'b0;
        #1;
        check("rst_mid_ctrl", {busy, s_rd_en, s_wr_en, wr_ovf}, 0);
        check("rst_mid_addr_data", {s_rd_addr, s_wr_addr, s_wr_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_valid = 1'b1;
        @(negedge clk);
        check("late_valid_ignored", {m0_rd_valid, m1_rd_valid}, 0);
        @(posedge clk);
        #1;
        force_valid = 1'b0;
        lat = 3;
        exp_rd(16'h0014, 3);
        exp_rd1.push_back(32'hC0DE_0005);
        m1_rd_addr = 16'h0014;
        m1_rd_en = 1'b1;
        drain("t5_after_reset");

        // Read-after-write from the same master sees the new data.
        exp_wr(16'h0050, 32'hA5A5_A5A5);
        exp_rd(16'h0050, 3);
        exp_rd1.push_back(32'hA5A5_A5A5);
        m1_wr_addr = 16'h0050;
        m1_wr_data = 32'hA5A5_A5A5;
        m1_wr_en = 1'b1;
        step();
        m1_rd_addr = 16'h0050;
        m1_rd_en = 1'b1;
        drain("t6_raw");

        // Simultaneous writes are both kept and drained in rr order.
        exp_wr(16'h0080, 32'h1111_0080);
        exp_wr(16'h0084, 32'h2222_0084);
        m0_wr_addr = 16'h0080;
        m0_wr_data = 32'h1111_0080;
        m1_wr_addr = 16'h0084;
        m1_wr_data = 32'h2222_0084;
        m0_wr_en = 1'b1;
        m1_wr_en = 1'b1;
        drain("t7_dual_write");
        check("no_ovf_dual_write", wr_ovf, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
